branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with a 2-bit bimodal direction predictor for the 5-stage RV32 pipeline. The IF stage looks up the current PC and gets a predicted next PC in the same cycle. The ID stage reports each resolved instruction back, and the block updates its table and flags mispredictions so the core can redirect. It replaces the fixed "predict not-taken, resolve in ID" scheme and adds saturating performance counters.

## Interface
- ENTRIES, 16, number of table entries; power of two, ≥2. INDEX_W = log2(ENTRIES).
- CNT_W, 32, width of each statistics counter.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- lookup_pc  in  32  IF-stage PC.
- pred_taken  out  1  prediction for lookup_pc (combinational).
- pred_target  out  32  predicted next PC (combinational).
- upd_valid  in  1  ID stage retires a resolution this cycle; one pulse per instruction; held low while the core stalls.
- upd_pc  in  32  PC of the resolving instruction.
- upd_is_branch  in  1  conditional branch.
- upd_is_jump  in  1  JAL or JALR.
- upd_taken  in  1  actual direction; 1 for jumps.
- upd_target  in  32  actual target.
- upd_pred_taken  in  1  pred_taken captured when this instruction was fetched.
- upd_pred_target  in  32  pred_target captured at fetch.
- flush  in  1  synchronous invalidate of all entries.
- mispredict  out  1  combinational redirect request.
- redirect_pc  out  32  correct next PC; valid when mispredict=1.
- stat_updates  out  CNT_W  count of resolved branches and jumps.
- stat_mispredicts  out  CNT_W  count of mispredict cycles.

## Operation
- Index is pc[INDEX_W+1:2]. Tag is pc[31:INDEX_W+2], TAG_W = 30-INDEX_W.
- Each entry holds: valid, tag, target[31:0], ctr[1:0], is_jump.
- Lookup: hit = valid & tag match. pred_taken = hit & (is_jump | ctr[1]). pred_target = pred_taken ? target : lookup_pc+4.
- Control-flow update (upd_valid & (upd_is_branch | upd_is_jump)), applied at the clock edge:
  - On a hit at the upd_pc index:
    - ctr saturating-increments if upd_taken, else saturating-decrements; limits are 2'b11 and 2'b00.
    - target is overwritten with upd_target only when upd_taken.
    - is_jump is overwritten with upd_is_jump.
  - On a miss with upd_taken: the entry is allocated or replaced. valid=1, tag loaded, target=upd_target, ctr=2'b10, is_jump=upd_is_jump.
  - On a miss with not taken: no table change.
- Aliasing (upd_valid, neither upd_is_branch nor upd_is_jump, upd_pred_taken=1): the entry at that index is invalidated if its tag matches upd_pc.
- mispredict = upd_valid & ( (upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target) ). A non-control instruction counts as upd_taken=0.
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Statistics:
  - stat_updates increments per control-flow update.
  - stat_mispredicts increments per mispredict cycle.
  - Both saturate at all-ones and are cleared only by reset.
- flush clears every valid bit. When flush and an update occur in the same cycle, flush wins and the update is dropped. Statistics still count that update.
- PC arithmetic is modulo 2^32; 0xFFFFFFFC+4 = 0x00000000.

## Timing
- Lookup has zero latency: pred_* depend combinationally on lookup_pc and the current table.
- Table updates become visible to lookup in the cycle after the update edge. A same-cycle lookup of the updated index sees the old contents.
- mispredict and redirect_pc have zero latency from the upd_* inputs.
- Reset asynchronously clears all valid bits, ctr, target, tag and both statistics counters. After reset: pred_taken=0, pred_target=lookup_pc+4, stat_*=0.
- Reset mid-update: the update is lost and the table is empty afterwards.
- Single write port: at most one table write per cycle.

## Test plan
- Reset with lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, stat_*=0.
- Loop branch at 0x40, taken to 0x20; resolve it taken four times:
  - 1st update: mispredict=1, redirect_pc=0x20; entry allocated with ctr=10.
  - Next cycle, lookup 0x40 -> pred_taken=1, pred_target=0x20.
  - After the 4th update, ctr=11.
  - Then resolve not-taken once -> mispredict=1, redirect_pc=0x44, ctr=10, prediction still taken.
  - Resolve not-taken again -> ctr=01, lookup 0x40 predicts not taken.
- Aliasing, ENTRIES=16: 0x40 and 0x440 share index 0.
  - Allocate 0x40, then resolve a JAL at 0x440 to 0x800 -> entry replaced.
  - Lookup 0x40 misses; lookup 0x440 gives pred_target=0x800.
- JALR predicted 0x300 but actual 0x340 -> mispredict=1, redirect_pc=0x340; target updated to 0x340.
- A non-branch instruction at 0x40 reports upd_pred_taken=1 -> mispredict=1, redirect_pc=0x44, entry invalidated.
- flush asserted together with an update to 0x80 -> all lookups miss next cycle, stat_updates still increments.
  - With CNT_W=4, 16 mispredicts -> stat_mispredicts holds at 4'hF.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: BTB with 2-bit bimodal direction counters, mispredict detection and saturating stats
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      i_lookup_pc,
    output logic             o_pred_taken,
    output logic [31:0]      o_pred_target,
    input  logic             i_upd_valid,
    input  logic [31:0]      i_upd_pc,
    input  logic             i_upd_is_branch,
    input  logic             i_upd_is_jump,
    input  logic             i_upd_taken,
    input  logic [31:0]      i_upd_target,
    input  logic             i_upd_pred_taken,
    input  logic [31:0]      i_upd_pred_target,
    input  logic             i_flush,
    output logic             o_mispredict,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_stat_updates,
    output logic [CNT_W-1:0] o_stat_mispredicts
);
    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_W   = 30 - INDEX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_is_jump;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [CNT_W-1:0]   r_stat_upd;
    logic [CNT_W-1:0]   r_stat_mis;

    logic [INDEX_W-1:0] w_l_idx, w_u_idx;
    logic [TAG_W-1:0]   w_l_tag, w_u_tag;
    logic               w_l_hit, w_u_hit, w_ctl, w_cf, w_taken;
    logic [1:0]         w_ctr, w_ctr_next;

    assign w_l_idx = i_lookup_pc[INDEX_W+1:2];
    assign w_l_tag = i_lookup_pc[31:INDEX_W+2];
    assign w_u_idx = i_upd_pc[INDEX_W+1:2];
    assign w_u_tag = i_upd_pc[31:INDEX_W+2];
    assign w_l_hit = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    assign o_pred_taken  = w_l_hit && (r_is_jump[w_l_idx] || r_ctr[w_l_idx][1]);
    assign o_pred_target = o_pred_taken ? r_target[w_l_idx] : i_lookup_pc + 32'd4;

    // Non-control instructions resolve as not taken
    assign w_ctl   = i_upd_is_branch || i_upd_is_jump;
    assign w_cf    = i_upd_valid && w_ctl;
    assign w_taken = w_ctl && i_upd_taken;

    assign o_mispredict  = i_upd_valid && ((i_upd_pred_taken != w_taken) ||
                           (w_taken && (i_upd_pred_target != i_upd_target)));
    assign o_redirect_pc = w_taken ? i_upd_target : i_upd_pc + 32'd4;

    assign w_ctr      = r_ctr[w_u_idx];
    assign w_ctr_next = i_upd_taken ? ((w_ctr == 2'b11) ? w_ctr : w_ctr + 2'd1)
                                    : ((w_ctr == 2'b00) ? w_ctr : w_ctr - 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= '0;
            r_is_jump <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (w_cf && w_u_hit) begin
            r_ctr[w_u_idx]     <= w_ctr_next;
            r_is_jump[w_u_idx] <= i_upd_is_jump;
            if (i_upd_taken)
                r_target[w_u_idx] <= i_upd_target;
        end else if (w_cf && i_upd_taken) begin
            r_valid[w_u_idx]   <= 1'b1;
            r_tag[w_u_idx]     <= w_u_tag;
            r_target[w_u_idx]  <= i_upd_target;
            r_ctr[w_u_idx]     <= 2'b10;
            r_is_jump[w_u_idx] <= i_upd_is_jump;
        end else if (i_upd_valid && !w_ctl && i_upd_pred_taken && w_u_hit) begin
            // A non-branch predicted taken means the entry belongs to another PC
            r_valid[w_u_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_upd <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_cf && !(&r_stat_upd))
                r_stat_upd <= r_stat_upd + CNT_W'(1);
            if (o_mispredict && !(&r_stat_mis))
                r_stat_mis <= r_stat_mis + CNT_W'(1);
        end
    end

    assign o_stat_updates     = r_stat_upd;
    assign o_stat_mispredicts = r_stat_mis;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table plus scoreboard for lookup, update, aliasing, flush and stats
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
    logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken, flush;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc, stat_updates, stat_mispredicts;
    logic        s_pred_taken, s_mispredict;
    logic [31:0] s_pred_target, s_redirect_pc;
    logic [3:0]  s_stat_updates, s_stat_mispredicts;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .reset(reset), .i_lookup_pc(lookup_pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_is_branch(upd_is_branch),
        .i_upd_is_jump(upd_is_jump), .i_upd_taken(upd_taken), .i_upd_target(upd_target),
        .i_upd_pred_taken(upd_pred_taken), .i_upd_pred_target(upd_pred_target),
        .i_flush(flush), .o_mispredict(mispredict), .o_redirect_pc(redirect_pc),
        .o_stat_updates(stat_updates), .o_stat_mispredicts(stat_mispredicts)
    );

    branch_predictor #(.ENTRIES(16), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .i_lookup_pc(lookup_pc),
        .o_pred_taken(s_pred_taken), .o_pred_target(s_pred_target),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_is_branch(upd_is_branch),
        .i_upd_is_jump(upd_is_jump), .i_upd_taken(upd_taken), .i_upd_target(upd_target),
        .i_upd_pred_taken(upd_pred_taken), .i_upd_pred_target(upd_pred_target),
        .i_flush(flush), .o_mispredict(s_mispredict), .o_redirect_pc(s_redirect_pc),
        .o_stat_updates(s_stat_updates), .o_stat_mispredicts(s_stat_mispredicts)
    );

    typedef struct {
        logic [31:0] lpc;
        logic        uv, br, jmp, tk;
        logic [31:0] upc, utgt;
        logic        uptk;
        logic [31:0] uptgt;
        logic        fl;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_rdr;
    } vec_t;

    typedef struct {
        int          row;
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] rdr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] lpc, input logic uv, br, jmp, tk,
                       input logic [31:0] upc, utgt, input logic uptk, input logic [31:0] uptgt,
                       input logic fl, input logic e_pt, input logic [31:0] e_ptgt,
                       input logic e_mis, input logic [31:0] e_rdr);
        vecs.push_back('{lpc, uv, br, jmp, tk, upc, utgt, uptk, uptgt, fl, e_pt, e_ptgt, e_mis, e_rdr});
    endtask

    task automatic drive(input logic [31:0] lpc, input logic uv, br, jmp, tk,
                         input logic [31:0] upc, utgt, input logic uptk, input logic [31:0] uptgt,
                         input logic fl);
        lookup_pc = lpc; upd_valid = uv; upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk;
        upd_pc = upc; upd_target = utgt; upd_pred_taken = uptk; upd_pred_target = uptgt; flush = fl;
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // loop branch at 0x40 -> 0x20: allocate, saturate up, decay, saturate down
        add(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44, 0, 0, 32'h44, 1, 32'h20);
        add(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 1, 32'h20, 0, 1, 32'h20, 0, 32'h20);
        add(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 1, 32'h20, 0, 1, 32'h20, 0, 32'h20);
        add(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 1, 32'h20, 0, 1, 32'h20, 0, 32'h20);
        add(32'h40, 1, 1, 0, 0, 32'h40, 32'h20, 1, 32'h20, 0, 1, 32'h20, 1, 32'h44);
        add(32'h40, 1, 1, 0, 0, 32'h40, 32'h20, 1, 32'h20, 0, 1, 32'h20, 1, 32'h44);
        add(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 32'h4);
        add(32'h40, 1, 1, 0, 0, 32'h40, 32'h20, 0, 32'h44, 0, 0, 32'h44, 0, 32'h44);
        add(32'h40, 1, 1, 0, 0, 32'h40, 32'h20, 0, 32'h44, 0, 0, 32'h44, 0, 32'h44);
        add(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44, 0, 0, 32'h44, 1, 32'h20);
        add(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 32'h4);
        // JAL at 0x440 aliases index 0 and replaces the 0x40 entry
        add(32'h440, 1, 0, 1, 1, 32'h440, 32'h800, 0, 32'h444, 0, 0, 32'h444, 1, 32'h800);
        add(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 32'h4);
        add(32'h440, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h800, 0, 32'h4);
        // JALR target change
        add(32'h104, 1, 0, 1, 1, 32'h104, 32'h300, 0, 32'h108, 0, 0, 32'h108, 1, 32'h300);
        add(32'h104, 1, 0, 1, 1, 32'h104, 32'h340, 1, 32'h300, 0, 1, 32'h300, 1, 32'h340);
        add(32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h340, 0, 32'h4);
        // non-branch predicted taken invalidates only on tag match
        add(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44, 0, 0, 32'h44, 1, 32'h20);
        add(32'h40, 1, 0, 0, 0, 32'h40, 32'h20, 1, 32'h20, 0, 1, 32'h20, 1, 32'h44);
        add(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 32'h4);
        add(32'h104, 1, 0, 0, 0, 32'h504, 0, 1, 32'h340, 0, 1, 32'h340, 1, 32'h508);
        add(32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h340, 0, 32'h4);
        // flush beats a same-cycle update
        add(32'h104, 1, 1, 0, 1, 32'h80, 32'h10, 0, 32'h84, 1, 1, 32'h340, 1, 32'h10);
        add(32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h108, 0, 32'h4);
        add(32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h84, 0, 32'h4);
        // PC wrap
        add(32'hFFFFFFFC, 1, 1, 0, 0, 32'hFFFFFFFC, 0, 1, 0, 0, 0, 32'h0, 1, 32'h0);
        add(32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h4);

        #12 reset = 1'b0;
        @(negedge clk);
        chk("reset pred_taken", 32'(pred_taken), 32'd0);
        chk("reset pred_target", pred_target, 32'h104);
        chk("reset stat_updates", stat_updates, 32'd0);
        chk("reset stat_mispredicts", stat_mispredicts, 32'd0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].lpc, vecs[i].uv, vecs[i].br, vecs[i].jmp, vecs[i].tk,
                  vecs[i].upc, vecs[i].utgt, vecs[i].uptk, vecs[i].uptgt, vecs[i].fl);
            sb.push_back('{i, vecs[i].e_pt, vecs[i].e_ptgt, vecs[i].e_mis, vecs[i].e_rdr});
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("row%0d pred_taken", e.row), 32'(pred_taken), 32'(e.pt));
            chk($sformatf("row%0d pred_target", e.row), pred_target, e.ptgt);
            chk($sformatf("row%0d mispredict", e.row), 32'(mispredict), 32'(e.mis));
            chk($sformatf("row%0d redirect_pc", e.row), redirect_pc, e.rdr);
        end

        @(posedge clk); #1;
        drive(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stat_updates", stat_updates, 32'd15);
        chk("stat_mispredicts", stat_mispredicts, 32'd12);
        chk("small stat_updates", 32'(s_stat_updates), 32'd15);
        chk("small stat_mispredicts", 32'(s_stat_mispredicts), 32'd12);

        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(32'h0, 1, 0, 0, 0, 32'h200, 0, 1, 32'h0, 0);
        end
        @(posedge clk); #1;
        drive(32'h0, 1, 1, 0, 0, 32'h200, 0, 0, 32'h204, 0);
        @(posedge clk); #1;
        drive(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stat_mispredicts 18", stat_mispredicts, 32'd18);
        chk("small stat_mispredicts sat", 32'(s_stat_mispredicts), 32'hF);
        chk("stat_updates 16", stat_updates, 32'd16);
        chk("small stat_updates sat", 32'(s_stat_updates), 32'hF);

        @(posedge clk); #1;
        drive(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44, 0);
        @(posedge clk); #1;
        drive(32'h40, 1, 1, 0, 1, 32'h40, 32'h60, 1, 32'h20, 0);
        @(negedge clk);
        chk("pre-reset hit", 32'(pred_taken), 32'd1);
        #2 reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post-reset pred_taken", 32'(pred_taken), 32'd0);
        chk("post-reset pred_target", pred_target, 32'h44);
        chk("post-reset stat_updates", stat_updates, 32'd0);
        chk("post-reset stat_mispredicts", stat_mispredicts, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
